ring_input_port: RTL

//  Input buffering stage of a ring router port (East, West or Local).
//  - Accepts flits from the upstream link under credit flow control and queues them in a FIFO.
//  - Presents the head-of-queue flit and its current-hop direction to the switch allocator.
//  - Rewrites the head flit's routing field with the next-hop direction, computed by an

---
 rtl/ring_input_port_pkg.sv | 46 ++++
 rtl/ring_input_port_if.sv | 28 ++
 rtl/ring_input_port_lookahead_routing.sv | 40 ++++
 rtl/ring_input_port.sv | 117 +++++++++++
 4 files changed

// File: rtl/ring_input_port_pkg.sv
// Shared ring NoC types: coordinates, directions, flit format and port FSM state.
package ring_input_port_pkg;

  localparam int kRingSize = 4;
  localparam int kCoordW   = $clog2(kRingSize);
  localparam int kPayloadW = 8;

  typedef struct packed {
    logic [kCoordW-1:0] x;
    logic [kCoordW-1:0] y;
  } xy_t;

  typedef enum logic [1:0] {
    goEast  = 2'd0,
    goWest  = 2'd1,
    goLocal = 2'd2
  } direction_t;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_type_e;

  // 'type' is a reserved word, so the flit kind lives in ftype.
  typedef struct packed {
    flit_type_e             ftype;
    xy_t                    dest;
    direction_t             routing;
    logic [kPayloadW-1:0]   payload;
  } flit_t;

  localparam int kFlitW = $bits(flit_t);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } port_state_e;

  // HEAD and HEADTAIL both open a packet and carry a routing decision.
  function automatic logic is_head_type(flit_type_e t);
    return (t == HEAD) || (t == HEADTAIL);
  endfunction

endpackage

// File: rtl/ring_input_port_if.sv
// Upstream link and switch-allocator signals of one ring router input port.
//
// Handshake: flit_valid_in pushes flit_in unconditionally; the upstream only sends
// while it holds a credit, and each credit_out pulse returns one slot. Downstream,
// a flit leaves in a cycle where flit_valid_out && grant_in; grant_in while
// flit_valid_out is low has no effect.
interface ring_input_port_if;
  import ring_input_port_pkg::*;

  flit_t      flit_in;
  logic       flit_valid_in;
  logic       credit_out;
  flit_t      flit_out;
  direction_t route_out;
  logic       flit_valid_out;
  logic       grant_in;

  modport master (
    output flit_in, flit_valid_in, grant_in,
    input  credit_out, flit_out, route_out, flit_valid_out
  );

  modport slave (
    input  flit_in, flit_valid_in, grant_in,
    output credit_out, flit_out, route_out, flit_valid_out
  );

endinterface

// File: rtl/ring_input_port_lookahead_routing.sv
// Next-hop direction for a head flit: where it will leave the router it enters next.
// Routing on the ring is unidirectional: a flit keeps its direction until the hop
// that lands on its destination column, where it turns Local.
module lookahead_routing
  import ring_input_port_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  xy_t        position,
  input  direction_t current_routing,
  input  xy_t        destination,
  output direction_t next_routing
);

  logic [kCoordW-1:0] pos_x_q;
  logic [kCoordW-1:0] hop_x;
  logic               unused_y;

  // Only the ring column matters; y is carried in the flit format but not routed on.
  assign unused_y = ^{position.y, destination.y};

  // Hold the tile coordinate locally; it is static after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pos_x_q <= '0;
    else        pos_x_q <= position.x;
  end

  // Column of the next router, then the direction to take out of it.
  always_comb begin
    hop_x        = pos_x_q;
    next_routing = current_routing;
    case (current_routing)
      goEast:  hop_x = (pos_x_q == kCoordW'(kRingSize - 1)) ? '0 : pos_x_q + 1'b1;
      goWest:  hop_x = (pos_x_q == '0) ? kCoordW'(kRingSize - 1) : pos_x_q - 1'b1;
      default: hop_x = pos_x_q;
    endcase
    if (current_routing == goLocal || hop_x == destination.x) next_routing = goLocal;
  end

endmodule

// File: rtl/ring_input_port.sv
// Ring router input port: credit-controlled FIFO, head-flit lookahead routing
// rewrite, and a route lock held for body flits until the tail leaves.
module ring_input_port
  import ring_input_port_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  xy_t               position,
  ring_input_port_if.slave  bus,
  output logic              overflow_err,
  output logic              protocol_err,
  output port_state_e       state_dbg,
  output logic [CNT_W-1:0]  count_dbg
);

  localparam int PTR_W = $clog2(DEPTH);

  flit_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  port_state_e      state;
  direction_t       route_lock;

  flit_t            head;
  direction_t       current;
  direction_t       next_routing;
  logic             head_is_head;
  logic             full;
  logic             pop;
  logic             push;

  assign head           = mem[rd_ptr];
  assign current        = head.routing;
  assign head_is_head   = is_head_type(head.ftype);
  assign full           = (count == CNT_W'(DEPTH));
  assign bus.flit_valid_out = (count != '0);
  assign pop            = bus.flit_valid_out && bus.grant_in;
  // A full queue still accepts when the head leaves in the same cycle.
  assign push           = bus.flit_valid_in && (!full || pop);

  assign state_dbg = state;
  assign count_dbg = count;

  lookahead_routing u_lookahead_routing (
    .clk             (clk),
    .rst_n           (rst_n),
    .position        (position),
    .current_routing (current),
    .destination     (head.dest),
    .next_routing    (next_routing)
  );

  // Head flits leave with the next hop's direction; body/tail follow the locked route.
  always_comb begin
    bus.flit_out  = head;
    bus.route_out = current;
    if (head_is_head)        bus.flit_out.routing = next_routing;
    else if (state == BUSY)  bus.route_out        = route_lock;
  end

  // Flit storage; contents are don't-care until count says otherwise.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.flit_in;
  end

  // Pointers, occupancy and one credit per departed flit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      bus.credit_out <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      bus.credit_out <= pop;
    end
  end

  // Sticky error flags: dropped flit, or a head/body flit arriving out of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_err <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (bus.flit_valid_in && full && !pop) overflow_err <= 1'b1;
      if (bus.flit_valid_out &&
          ((state == IDLE && !head_is_head) || (state == BUSY && head_is_head)))
        protocol_err <= 1'b1;
    end
  end

  // Packet FSM, advancing only when a flit departs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      route_lock <= goEast;
    end else if (pop) begin
      if (head_is_head) begin
        route_lock <= current;
        state      <= (head.ftype == HEAD) ? BUSY : IDLE;
      end else if (head.ftype == TAIL) begin
        state <= IDLE;
      end
    end
  end

endmodule
